sysid_regs: RTL and testbench

SYSID_REGS -- requirements
Module: sysid_regs

---
 rtl/sysid_regs_pkg.sv | 29 ++
 rtl/sysid_uptime_ctr.sv | 61 ++++++
 rtl/sysid_regs.sv | 106 ++++++++++
 tb/tb_sysid_regs.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_regs_pkg.sv
// Shared constants for the system-ID register block: word map, CTRL bit
// positions, scratch-count limits and the byte-lane merge helper.
package sysid_regs_pkg;

  localparam logic [3:0] ADDR_ID         = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP  = 4'd1;
  localparam logic [3:0] ADDR_UPTIME_LO  = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_HI  = 4'd3;
  localparam logic [3:0] ADDR_CTRL       = 4'd4;
  localparam logic [3:0] ADDR_SCRATCH0   = 4'd5;

  localparam int unsigned CTRL_CLEAR_BIT  = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;

  localparam int unsigned NUM_SCRATCH_MIN = 1;
  localparam int unsigned NUM_SCRATCH_MAX = 4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running 64-bit uptime counter with prescaler, clear/freeze control and
// a high-word shadow captured whenever the low word is read.
module sysid_uptime_ctr
  import sysid_regs_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        freeze_i,
  input  logic        capture_i,
  output logic [31:0] count_lo_o,
  output logic [31:0] shadow_o
);

  localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

  logic [15:0] pre_q, pre_d;
  logic [63:0] count_q, count_d;
  logic [31:0] shadow_q, shadow_d;

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves one unassigned (which would otherwise infer a latch).
  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    if (clear_i) begin
      pre_d   = '0;
      count_d = '0;
    end else if (!freeze_i) begin
      if (pre_q == PRE_MAX) begin
        pre_d   = '0;
        count_d = count_q + 64'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
    // Shadow takes the high word of the same cycle the low word is returned.
    if (capture_i) shadow_d = count_q[63:32];
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // this is also what lets a same-cycle read see the pre-write contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign count_lo_o = count_q[31:0];
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/sysid_regs.sv
// System-ID / timestamp / scratch register slave with fixed 1-cycle read latency.
// Uptime counter, shadow and CTRL exist only when SYSID_UPTIME_EN is defined.
module sysid_regs
  import sysid_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h0,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  if (NUM_SCRATCH < NUM_SCRATCH_MIN || NUM_SCRATCH > NUM_SCRATCH_MAX) begin : g_bad_scratch
    $error("sysid_regs: NUM_SCRATCH must be 1..4");
  end
  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick
    $error("sysid_regs: TICK_DIV must be 1..65535");
  end

  logic [31:0]            scratch_q [NUM_SCRATCH];
  logic [NUM_SCRATCH-1:0] scratch_sel;
  logic [31:0]            rdata_d;
  logic [31:0]            readdata_q;
  logic                   rvalid_q;

`ifdef SYSID_UPTIME_EN
  logic        freeze_q, freeze_d;
  logic        ctrl_wr, clear;
  logic [31:0] up_lo, up_shadow;

  assign ctrl_wr  = write && (address == ADDR_CTRL) && byteenable[0];
  assign clear    = ctrl_wr && writedata[CTRL_CLEAR_BIT];
  assign freeze_d = ctrl_wr ? writedata[CTRL_FREEZE_BIT] : freeze_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) freeze_q <= 1'b0;
    else          freeze_q <= freeze_d;
  end

  sysid_uptime_ctr #(.TICK_DIV(TICK_DIV)) u_uptime (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .clear_i    (clear),
    .freeze_i   (freeze_q),
    .capture_i  (read && (address == ADDR_UPTIME_LO)),
    .count_lo_o (up_lo),
    .shadow_o   (up_shadow)
  );
`endif

  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_sel[i] = (address == ADDR_SCRATCH0 + 4'(i));
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_ID:        rdata_d = ID_VALUE;
      ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
      ADDR_UPTIME_LO: rdata_d = up_lo;
      ADDR_UPTIME_HI: rdata_d = up_shadow;
      ADDR_CTRL:      rdata_d = 32'(freeze_q) << CTRL_FREEZE_BIT;
`else
      ADDR_UPTIME_LO, ADDR_UPTIME_HI, ADDR_CTRL: rdata_d = '0;
`endif
      default:        rdata_d = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (scratch_sel[i]) rdata_d = scratch_q[i];
    end
  end

  // NOTE: scratch is a few discrete flops rather than a RAM macro, so it can
  // take the async reset; an inferred memory array generally could not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      rvalid_q <= read;
      if (read) readdata_q <= rdata_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write && scratch_sel[i]) begin
          scratch_q[i] <= merge_bytes(scratch_q[i], writedata, byteenable);
        end
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: expected read data is queued when a read is
// issued and compared when readdatavalid appears. Uptime tests need SYSID_UPTIME_EN.
module tb_sysid_regs;
  import sysid_regs_pkg::*;

  localparam logic [31:0] ID  = 32'h67BE_1A24;
  localparam logic [31:0] TS  = 32'h2024_0607;
  localparam int          NS  = 2;
  localparam int          TD  = 4;

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_regs #(
    .ID_VALUE    (ID),
    .TIMESTAMP   (TS),
    .NUM_SCRATCH (NS),
    .TICK_DIV    (TD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] exp;
    int unsigned tol;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rel_cyc  = 0;
  exp_t        mon_e;
  logic [31:0] mon_diff;

  always @(posedge clock) if (reset_n) cyc <= cyc + 1;

  // Scoreboard: every valid beat must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && readdatavalid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got=%h required=no readdatavalid", readdata);
      end else begin
        mon_e    = sb_q.pop_front();
        mon_diff = (readdata >= mon_e.exp) ? readdata - mon_e.exp : mon_e.exp - readdata;
        if (mon_diff > mon_e.tol) begin
          failures++;
          $display("FAIL %s got=%h required=%h tol=%0d", mon_e.name, readdata, mon_e.exp, mon_e.tol);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] e, input int unsigned tol, input string name);
    exp_t x;
    x.exp  = e;
    x.tol  = tol;
    x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e, input int unsigned tol,
                         input string name);
    @(negedge clock);
    address = a; read = 1'b1; write = 1'b0; byteenable = 4'h0;
    push_exp(e, tol, name);
  endtask

  // Expected uptime derived from the bench's own count of edges since release.
  task automatic do_read_up(input string name);
    int k;
    @(negedge clock);
    k = cyc - rel_cyc;
    address = ADDR_UPTIME_LO; read = 1'b1; write = 1'b0; byteenable = 4'h0;
    push_exp(32'(k / TD), 1, name);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address = a; read = 1'b0; write = 1'b1; writedata = d; byteenable = be;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] e, input string name);
    @(negedge clock);
    address = a; read = 1'b1; write = 1'b1; writedata = d; byteenable = be;
    push_exp(e, 0, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (sb_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout outstanding=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata got=%h required=%h", readdata, 32'h0);
    end
    checks++;
    if (readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b required=0", readdatavalid);
    end
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_id();
    do_read(ADDR_ID, ID, 0, "id_read");
    @(negedge clock);
    read = 1'b0;
    checks++;
    if (readdatavalid !== 1'b1 || readdata !== ID) begin
      failures++;
      $display("FAIL id_latency got=%b/%h required=1/%h", readdatavalid, readdata, ID);
    end
    @(negedge clock);
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== ID) begin
      failures++;
      $display("FAIL id_pulse_hold got=%b/%h required=0/%h", readdatavalid, readdata, ID);
    end
    do_read(ADDR_TIMESTAMP, TS, 0, "timestamp_read");
    drain();
  endtask

  task automatic test_scratch();
    do_write(ADDR_SCRATCH0, 32'hFFFF_FFFF, 4'hF);
    do_write(ADDR_SCRATCH0, 32'h0000_00AB, 4'b0001);
    do_read(ADDR_SCRATCH0, 32'hFFFF_FFAB, 0, "scratch0_byte_lane");
    do_read(4'd15, 32'h0, 0, "unmapped_15");
    do_read(4'd7, 32'h0, 0, "unmapped_past_scratch");
    do_write(ADDR_SCRATCH0 + 4'd1, 32'h1234_5678, 4'b1100);
    do_read(ADDR_SCRATCH0 + 4'd1, 32'h1234_0000, 0, "scratch1_upper_lanes");
    do_write(ADDR_SCRATCH0 + 4'd1, 32'hDEAD_BEEF, 4'b0000);
    do_read(ADDR_SCRATCH0 + 4'd1, 32'h1234_0000, 0, "scratch1_be_zero");
    do_write(ADDR_ID, 32'hDEAD_BEEF, 4'hF);
    do_write(ADDR_TIMESTAMP, 32'hDEAD_BEEF, 4'hF);
    do_read(ADDR_ID, ID, 0, "id_after_ro_write");
    do_read(ADDR_TIMESTAMP, TS, 0, "ts_after_ro_write");
    drain();
  endtask

  task automatic test_back_to_back();
    do_rw(ADDR_SCRATCH0 + 4'd1, 32'hCAFE_F00D, 4'hF, 32'h1234_0000, "raw_pre_write_value");
    do_read(ADDR_SCRATCH0 + 4'd1, 32'hCAFE_F00D, 0, "raw_committed");
    do_read(ADDR_SCRATCH0, 32'hFFFF_FFAB, 0, "b2b_scratch0");
    do_read(ADDR_ID, ID, 0, "b2b_id");
    do_read(4'd12, 32'h0, 0, "b2b_unmapped");
    drain();
  endtask

`ifdef SYSID_UPTIME_EN
  task automatic test_uptime_rate();
    while ((cyc - rel_cyc) < 40) idle(1);
    do_read_up("uptime_40_clocks");
    do_read(ADDR_UPTIME_HI, 32'h0, 0, "uptime_hi_shadow");
    drain();
  endtask

  task automatic test_freeze();
    int fz;
    do_write(ADDR_CTRL, 32'(1) << CTRL_FREEZE_BIT, 4'h1);
    fz = (cyc - rel_cyc + 1) / TD;
    do_read(ADDR_UPTIME_LO, 32'(fz), 1, "freeze_start");
    idle(20);
    do_read(ADDR_UPTIME_LO, 32'(fz), 1, "freeze_after_20");
    do_write(ADDR_CTRL, (32'(1) << CTRL_FREEZE_BIT) | (32'(1) << CTRL_CLEAR_BIT), 4'h1);
    do_read(ADDR_UPTIME_LO, 32'h0, 0, "clear_while_frozen");
    idle(5);
    do_read(ADDR_UPTIME_LO, 32'h0, 0, "cleared_stays_frozen");
    do_read(ADDR_CTRL, 32'h2, 0, "ctrl_readback");
    do_write(ADDR_CTRL, 32'h0, 4'h1);
    do_read(ADDR_CTRL, 32'h0, 0, "ctrl_unfrozen");
    drain();
  endtask

  task automatic test_carry();
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    force dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
    force dut.u_uptime.pre_q   = 16'd0;
    #1;
    release dut.u_uptime.count_q;
    release dut.u_uptime.pre_q;
    do_read(ADDR_UPTIME_LO, 32'hFFFF_FFFF, 0, "carry_lo_before");
    idle(6);
    do_read(ADDR_UPTIME_HI, 32'h0, 0, "carry_hi_before");
    drain();
    @(negedge clock);
    force dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
    force dut.u_uptime.pre_q   = 16'd0;
    #1;
    release dut.u_uptime.count_q;
    release dut.u_uptime.pre_q;
    idle(5);
    do_read(ADDR_UPTIME_LO, 32'h0, 0, "carry_lo_after");
    do_read(ADDR_UPTIME_HI, 32'h1, 0, "carry_hi_after");
    drain();
  endtask
`else
  task automatic test_no_uptime();
    do_write(ADDR_CTRL, 32'h3, 4'hF);
    do_write(ADDR_UPTIME_LO, 32'h5555_5555, 4'hF);
    idle(8);
    do_read(ADDR_UPTIME_LO, 32'h0, 0, "no_uptime_lo");
    do_read(ADDR_UPTIME_HI, 32'h0, 0, "no_uptime_hi");
    do_read(ADDR_CTRL, 32'h0, 0, "no_uptime_ctrl");
    drain();
  endtask
`endif

  task automatic test_reset_mid_read();
    int stray;
    @(negedge clock);
    address = ADDR_SCRATCH0; read = 1'b1; write = 1'b0;
    #2 reset_n = 1'b0;
    #1 read = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (readdatavalid !== 1'b0 || readdata !== 32'h0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_hold_outputs got=%0d bad cycles required=0", stray);
    end
    reset_n = 1'b1;
    rel_cyc = cyc;
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (readdatavalid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL dropped_read_valid got=%0d valid cycles required=0", stray);
    end
    do_read(ADDR_SCRATCH0, 32'h0, 0, "scratch0_after_reset");
    do_read(ADDR_SCRATCH0 + 4'd1, 32'h0, 0, "scratch1_after_reset");
`ifdef SYSID_UPTIME_EN
    do_read_up("uptime_after_reset");
    do_read(ADDR_UPTIME_HI, 32'h0, 0, "shadow_after_reset");
    do_read(ADDR_CTRL, 32'h0, 0, "ctrl_after_reset");
`endif
    drain();
  endtask

  initial begin
    test_reset();
`ifdef SYSID_UPTIME_EN
    test_uptime_rate();
`endif
    test_id();
    test_scratch();
    test_back_to_back();
`ifdef SYSID_UPTIME_EN
    test_freeze();
    test_carry();
`else
    test_no_uptime();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
